// File: rtl/pipelined_cla_adder_if.sv
// Operand/result stream bundle for the pipelined CLA adder.
// Latency: none (wiring only).
// Backpressure: in_ready/out_ready are carried alongside their valid signals.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             CIN;
    logic             SUB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
    logic             OVF;

    modport master (
        output in_valid, X, Y, CIN, SUB, out_ready,
        input  in_ready, out_valid, SUM, COUT, OVF
    );

    modport slave (
        input  in_valid, X, Y, CIN, SUB, out_ready,
        output in_ready, out_valid, SUM, COUT, OVF
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: bit G/P, then group carries, then sum/flags.
// Latency: 3 cycles from accepted beat to out_valid; one beat per cycle when unstalled.
// Backpressure: a held result (out_valid & ~out_ready) freezes every stage and drops in_ready.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int NGRP = WIDTH / GROUP;

    if (GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_bad_param
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of GROUP");
    end

    logic adv;

    // stage 1: bitwise generate/propagate
    logic [WIDTH-1:0] ye;
    logic             cin_e;
    logic             s1_vld;
    logic [WIDTH-1:0] s1_g;
    logic [WIDTH-1:0] s1_p;
    logic             s1_cin;

    // stage 2: group carries
    logic [NGRP:0]    gc;
    logic             gg;
    logic             gp;
    logic             s2_vld;
    logic [WIDTH-1:0] s2_g;
    logic [WIDTH-1:0] s2_p;
    logic [NGRP:0]    s2_gc;

    // stage 3: per-bit carries
    logic [WIDTH:0]   c;
    logic             cur;

    assign adv          = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        ye    = bus.SUB ? ~bus.Y : bus.Y;
        cin_e = bus.SUB ? 1'b1 : bus.CIN;
    end

    // Carry crosses all group boundaries within this one combinational cycle.
    always_comb begin
        gc    = '0;
        gg    = 1'b0;
        gp    = 1'b1;
        gc[0] = s1_cin;
        for (int k = 0; k < NGRP; k++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int j = 0; j < GROUP; j++) begin
                gg = s1_g[k*GROUP+j] | (s1_p[k*GROUP+j] & gg);
                gp = gp & s1_p[k*GROUP+j];
            end
            gc[k+1] = gg | (gp & gc[k]);
        end
    end

    always_comb begin
        c   = '0;
        cur = 1'b0;
        for (int k = 0; k < NGRP; k++) begin
            cur = s2_gc[k];
            for (int j = 0; j < GROUP; j++) begin
                c[k*GROUP+j] = cur;
                cur = s2_g[k*GROUP+j] | (s2_p[k*GROUP+j] & cur);
            end
        end
        c[WIDTH] = s2_gc[NGRP];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld        <= 1'b0;
            s1_g          <= '0;
            s1_p          <= '0;
            s1_cin        <= 1'b0;
            s2_vld        <= 1'b0;
            s2_g          <= '0;
            s2_p          <= '0;
            s2_gc         <= '0;
            bus.out_valid <= 1'b0;
            bus.SUM       <= '0;
            bus.COUT      <= 1'b0;
            bus.OVF       <= 1'b0;
        end else if (adv) begin
            s1_vld        <= bus.in_valid;
            s1_g          <= bus.X & ye;
            s1_p          <= bus.X ^ ye;
            s1_cin        <= cin_e;
            s2_vld        <= s1_vld;
            s2_g          <= s1_g;
            s2_p          <= s1_p;
            s2_gc         <= gc;
            bus.out_valid <= s2_vld;
            // Result registers keep their last value across bubbles.
            if (s2_vld) begin
                bus.SUM  <= s2_p ^ c[WIDTH-1:0];
                bus.COUT <= c[WIDTH];
                bus.OVF  <= c[WIDTH] ^ c[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed-vector bench for pipelined_cla_adder (WIDTH=16, GROUP=4).
// Expected results are hand-computed constants in the vector table.
module tb_pipelined_cla_adder;
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_q[$];
    int   beat_cnt = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    vec_t tbl[12];

    pipelined_cla_adder_if #(.WIDTH(16)) bus ();

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: a result is consumed at the edge following a negedge with valid & ready.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    int idx;
                    idx = exp_q.pop_front();
                    chk($sformatf("sum[%0d]", idx), bus.SUM, tbl[idx].s);
                    chk($sformatf("cout[%0d]", idx), bus.COUT, tbl[idx].co);
                    chk($sformatf("ovf[%0d]", idx), bus.OVF, tbl[idx].ov);
                end
                if (beat_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                beat_cnt++;
            end
        end
    end

    task automatic push(input int idx);
        int guard;
        guard        = 0;
        bus.X        = tbl[idx].x;
        bus.Y        = tbl[idx].y;
        bus.CIN      = tbl[idx].cin;
        bus.SUB      = tbl[idx].sub;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
        exp_q.push_back(idx);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_drained"}, exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            x         y         cin   sub   sum       co    ov
        tbl[0]  = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
        tbl[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[6]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        tbl[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[8]  = '{16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[9]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tbl[10] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
        tbl[11] = '{16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.X         = '0;
        bus.Y         = '0;
        bus.CIN       = 1'b0;
        bus.SUB       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 32'd0);
        chk("rst_sum", bus.SUM, 32'd0);
        chk("rst_cout", bus.COUT, 32'd0);
        chk("rst_ovf", bus.OVF, 32'd0);
        chk("rst_in_ready", bus.in_ready, 32'd1);

        // Exact 3-cycle latency, then output holds through a bubble.
        @(posedge clk);
        #1;
        bus.X = tbl[0].x; bus.Y = tbl[0].y; bus.CIN = tbl[0].cin; bus.SUB = tbl[0].sub;
        bus.in_valid = 1'b1;
        exp_q.push_back(0);
        @(negedge clk);
        chk("lat_in_ready", bus.in_ready, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_c1_vld", bus.out_valid, 32'd0);
        @(negedge clk);
        chk("lat_c2_vld", bus.out_valid, 32'd0);
        @(negedge clk);
        chk("lat_c3_vld", bus.out_valid, 32'd1);
        @(negedge clk);
        chk("bubble_vld", bus.out_valid, 32'd0);
        chk("bubble_sum_hold", bus.SUM, 32'h0003);
        drain("single0");

        for (int i = 1; i <= 3; i++) begin
            push(i);
            drain($sformatf("single%0d", i));
        end

        // Eight beats back to back must come out on eight consecutive cycles.
        beat_cnt = 0;
        for (int i = 4; i <= 11; i++) push(i);
        drain("b2b");
        chk("b2b_count", beat_cnt, 32'd8);
        chk("b2b_span", last_cyc - first_cyc, 32'd7);

        // Full pipe under a 5-cycle stall.
        beat_cnt = 0;
        bus.out_ready = 1'b0;
        push(0);
        push(1);
        push(2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", bus.in_ready, 32'd0);
            chk("stall_vld", bus.out_valid, 32'd1);
            chk("stall_sum", bus.SUM, 32'h0003);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain("stall");
        chk("stall_count", beat_cnt, 32'd3);

        // Reset with three beats in flight discards all of them.
        bus.out_ready = 1'b0;
        push(5);
        push(6);
        push(7);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_vld", bus.out_valid, 32'd0);
        chk("midrst_sum", bus.SUM, 32'd0);
        chk("midrst_in_ready", bus.in_ready, 32'd1);
        beat_cnt = 0;
        bus.out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_no_stale", beat_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
